// File: rtl/pio_button_pkg.sv
// ----------------------------------------------------------------------------
// Module      : pio_button_pkg
// Description : Shared types and constants for the button PIO sequencer.
//               This includes the FSM states, the PIO register map and the
//               button bit positions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package pio_button_pkg;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    CLR     = 3'd4
  } state_t;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;
  localparam int BTN_HOME = 2;
  localparam int BTN_MODE = 3;

endpackage

`default_nettype wire

// File: rtl/pio_poll_timer.sv
// ----------------------------------------------------------------------------
// Module      : pio_poll_timer
// Description : Reloadable down-counter. tick is high while the count is zero.
//               An enabled step at zero wraps back to PERIOD-1.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pio_poll_timer #(
  parameter int PERIOD = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic reload,
  output logic tick
);

  localparam int c_cnt_w = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(PERIOD - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Count down while enabled; an explicit reload always wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= c_reload;
    end else if (reload) begin
      r_cnt <= c_reload;
    end else if (en) begin
      r_cnt <= (r_cnt == '0) ? c_reload : r_cnt - c_cnt_w'(1);
    end
  end

  assign tick = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pio_button_sequencer.sv
// ----------------------------------------------------------------------------
// Module      : pio_button_sequencer
// Description : Avalon-MM master for the 4-button PIO. It writes irq_mask
//               once after reset. It then polls edge_capture on a timer or on
//               irq, and clears any non-zero capture. Presses are merged into
//               a held valid/ready event and step a wrapping image index.
//               Optional: define SLIDESHOW_EN to add the slideshow_on toggle
//               (button 3) with a periodic auto-advance.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pio_button_sequencer
  import pio_button_pkg::*;
#(
  parameter int         POLL_PERIOD   = 50000,
  parameter int         NUM_IMAGES    = 4,
  parameter int         IDX_W         = 2,
  parameter logic [3:0] IRQ_MASK_INIT = 4'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  output logic             event_valid,
  output logic [3:0]       event_buttons,
  input  logic             event_ready,
  output logic [IDX_W-1:0] image_index
`ifdef SLIDESHOW_EN
  ,
  output logic             slideshow_on
`endif
);

  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_IMAGES - 1);

  state_t           r_state, w_next_state;
  logic [1:0]       r_addr, w_addr;
  logic             r_cs, w_cs, r_wn, w_wn;
  logic [31:0]      r_wd, w_wd;
  logic [3:0]       r_cap;
  logic             r_event_valid;
  logic [3:0]       r_event_buttons;
  logic [IDX_W-1:0] r_index, w_btn_index, w_next_index;
  logic             w_btn_upd, w_auto, w_poll_tick, w_poll_reload, w_poll_expiry;
  logic             w_load, w_accept;
  logic             w_unused_rdata;

  function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] v);
    return (v == c_idx_last) ? '0 : v + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] f_dec(input logic [IDX_W-1:0] v);
    return (v == '0) ? c_idx_last : v - IDX_W'(1);
  endfunction

  assign w_unused_rdata = ^pio_readdata[31:4];
  assign w_poll_expiry  = (r_state == IDLE) && w_poll_tick;
  assign w_load         = (r_state == CLR);
  assign w_accept       = r_event_valid && event_ready;

  pio_poll_timer #(.PERIOD(POLL_PERIOD)) u_poll_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (r_state == IDLE),
    .reload  (w_poll_reload),
    .tick    (w_poll_tick)
  );

  // Next-state decision; the poll timer reloads whenever IDLE is left
  always_comb begin
    w_next_state  = r_state;
    w_poll_reload = 1'b0;
    case (r_state)
      INIT:    w_next_state = IDLE;
      IDLE: begin
        if (w_poll_tick || pio_irq) begin
          w_next_state  = RD_ADDR;
          w_poll_reload = 1'b1;
        end
      end
      RD_ADDR: w_next_state = RD_DATA;
      RD_DATA: w_next_state = (pio_readdata[3:0] == 4'b0) ? IDLE : CLR;
      CLR:     w_next_state = IDLE;
      default: w_next_state = INIT;
    endcase
  end

  // Bus values registered alongside the state they belong to. The irq_mask
  // write is loaded on the first edge out of reset, so the bus idles during reset.
  always_comb begin
    w_addr = PIO_ADDR_DATA;
    w_cs   = 1'b0;
    w_wn   = 1'b1;
    w_wd   = 32'h0;
    if (r_state == INIT) begin
      w_addr = PIO_ADDR_IRQMASK;
      w_cs   = 1'b1;
      w_wn   = 1'b0;
      w_wd   = {28'b0, IRQ_MASK_INIT};
    end else if (w_next_state == RD_ADDR) begin
      w_addr = PIO_ADDR_EDGECAP;
      w_cs   = 1'b1;
    end else if (w_next_state == CLR) begin
      w_addr = PIO_ADDR_EDGECAP;
      w_cs   = 1'b1;
      w_wn   = 1'b0;
      w_wd   = 32'h0000_000F;
    end
  end

  // State, bus and capture registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= INIT;
      r_addr  <= PIO_ADDR_DATA;
      r_cs    <= 1'b0;
      r_wn    <= 1'b1;
      r_wd    <= 32'h0;
      r_cap   <= 4'h0;
    end else begin
      r_state <= w_next_state;
      r_addr  <= w_addr;
      r_cs    <= w_cs;
      r_wn    <= w_wn;
      r_wd    <= w_wd;
      if (r_state == RD_DATA) begin
        r_cap <= pio_readdata[3:0];
      end
    end
  end

  // Button decode for the index; home overrides next/prev, next+prev cancel
  always_comb begin
    w_btn_index = r_index;
    w_btn_upd   = w_load && (r_cap[BTN_HOME] || r_cap[BTN_NEXT] || r_cap[BTN_PREV]);
    if (r_cap[BTN_HOME]) begin
      w_btn_index = '0;
    end else if (r_cap[BTN_NEXT] && r_cap[BTN_PREV]) begin
      w_btn_index = r_index;
    end else if (r_cap[BTN_NEXT]) begin
      w_btn_index = f_inc(r_index);
    end else if (r_cap[BTN_PREV]) begin
      w_btn_index = f_dec(r_index);
    end
    w_next_index = w_btn_upd ? w_btn_index : (w_auto ? f_inc(r_index) : r_index);
  end

`ifdef SLIDESHOW_EN
  logic r_slideshow_on;
  logic w_slide_tick;
  logic w_toggle;

  assign w_toggle = w_load && r_cap[BTN_MODE];

  pio_poll_timer #(.PERIOD(1024)) u_slide_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_poll_expiry),
    .reload  (w_toggle),
    .tick    (w_slide_tick)
  );

  // Mode button flips the slideshow on or off
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slideshow_on <= 1'b0;
    end else if (w_toggle) begin
      r_slideshow_on <= ~r_slideshow_on;
    end
  end

  assign w_auto       = r_slideshow_on && w_poll_expiry && w_slide_tick;
  assign slideshow_on = r_slideshow_on;
`else
  assign w_auto = 1'b0 & w_poll_expiry;
`endif

  // Index and event registers; a load in CLR beats a same-cycle accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_index         <= '0;
      r_event_valid   <= 1'b0;
      r_event_buttons <= 4'h0;
    end else begin
      r_index <= w_next_index;
      if (w_load) begin
        r_event_valid   <= 1'b1;
        r_event_buttons <= (r_event_valid && !w_accept) ? (r_event_buttons | r_cap) : r_cap;
      end else if (w_accept) begin
        r_event_valid   <= 1'b0;
        r_event_buttons <= 4'h0;
      end
    end
  end

  assign pio_address    = r_addr;
  assign pio_chipselect = r_cs;
  assign pio_write_n    = r_wn;
  assign pio_writedata  = r_wd;
  assign event_valid    = r_event_valid;
  assign event_buttons  = r_event_buttons;
  assign image_index    = r_index;

endmodule

`default_nettype wire
